// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, flush and read-valid strobe.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 1024,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
`ifdef SYNC_FIFO_ERR_EN
    output logic                       overflow,
    output logic                       underflow,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

    if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
        $error("sync_fifo_param: need AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_active;

    assign full         = (r_count == CNT_FULL);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= CNT_AF);
    assign almost_empty = (r_count <= CNT_AE);
    assign count        = r_count;
    assign dout         = r_dout;
    assign dout_valid   = r_dout_valid;

    // Accesses are suppressed entirely in reset and flush cycles, including the memory write.
    assign w_active = rst & ~flush;
    assign w_wr_acc = w_active & wr_en & ~full;
    assign w_rd_acc = w_active & rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    // A drop in the flush cycle itself still sets the flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                r_overflow <= 1'b1;
            end else if (flush) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                r_underflow <= 1'b1;
            end else if (flush) begin
                r_underflow <= 1'b0;
            end
        end
    end
`endif

endmodule
